adder_selfcheck_seq: RTL and testbench

Exhaustive self-checking sequencer for the registered prefix-adder wrapper. Sweeps every `{a,b}` operand pair into the wrapper and compares the wrapper's registered `sum`/`cout` against an internally delayed golden result. Reports a saturating mismatch count plus pass/done status. Sits on both sides of the adder wrapper: it drives the wrapper's inputs and consumes its outputs, so adder implementations can be checked on silicon/FPGA and in gate-level runs without a testbench.

---
 rtl/adder_selfcheck_if.sv | 45 ++++
 rtl/adder_selfcheck_seq.sv | 150 +++++++++++++++
 tb/tb_adder_selfcheck_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adder_selfcheck_if.sv
// adder_selfcheck_seq_if: bundles the start/status and wrapper-facing signals
// of the exhaustive adder self-check sequencer.
// Optional feature macro: ADDER_SELFCHECK_FIRSTERR_EN adds first_err_a/first_err_b.
interface adder_selfcheck_seq_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
);
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
    logic [WIDTH-1:0] first_err_a;
    logic [WIDTH-1:0] first_err_b;

    // Sequencer side: drives operands and status, consumes wrapper results.
    modport master (
        input  start, sum_in, cout_in,
        output a_out, b_out, busy, done, pass, err_count, first_err_a, first_err_b
    );

    // Environment side: starts sweeps, returns wrapper results.
    modport slave (
        output start, sum_in, cout_in,
        input  a_out, b_out, busy, done, pass, err_count, first_err_a, first_err_b
    );
`else
    // Sequencer side: drives operands and status, consumes wrapper results.
    modport master (
        input  start, sum_in, cout_in,
        output a_out, b_out, busy, done, pass, err_count
    );

    // Environment side: starts sweeps, returns wrapper results.
    modport slave (
        output start, sum_in, cout_in,
        input  a_out, b_out, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/adder_selfcheck_seq.sv
// adder_selfcheck_seq: sweeps every {a,b} operand pair into a registered adder
// wrapper and compares its sum/cout against a delayed golden result.
// Optional feature macro: ADDER_SELFCHECK_FIRSTERR_EN captures the operands of
// the first mismatching vector on first_err_a/first_err_b.
module adder_selfcheck_seq #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2,
    parameter int ERR_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_selfcheck_seq_if.master bus
);
    localparam int VW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One expected-pipe entry; MSB of exp is the expected carry.
    typedef struct packed {
        logic             valid;
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
        logic [VW-1:0]    ops;
`endif
        logic [WIDTH:0]   exp;
    } entry_t;

    state_t           state, state_nxt;
    logic             launch;
    logic [VW-1:0]    vec;          // {a_out,b_out}; doubles as the vector counter
    logic [CNT_W-1:0] drain_cnt;
    entry_t           pipe [LATENCY];
    entry_t           push;
    entry_t           head;
    logic             mismatch;
    logic [ERR_W-1:0] err_count, err_nxt;
    logic             busy, done, pass;
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
    logic [WIDTH-1:0] first_err_a, first_err_b;
`endif

    // State register.
    // NOTE: every flop in this design is written with <= so all registers
    // update from the same pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: launch from IDLE, finish RUN on the last vector,
    // drain the pipe for LATENCY cycles, then a single DONE cycle.
    // NOTE: defaults are assigned first so no path leaves a signal unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN:     if (vec == '1) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == CNT_W'(LATENCY - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Golden entry for the vector currently on a_out/b_out, plus compare at the pipe head.
    always_comb begin
        push       = '0;
        push.valid = (state == RUN);
        push.exp   = {1'b0, vec[VW-1:WIDTH]} + {1'b0, vec[WIDTH-1:0]};
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
        push.ops   = vec;
`endif
        head     = pipe[LATENCY-1];
        mismatch = head.valid && ({bus.cout_in, bus.sum_in} != head.exp);
        err_nxt  = err_count;
        if (launch)                            err_nxt = '0;
        else if (mismatch && err_count != '1)  err_nxt = err_count + 1'b1;
    end

    // Expected-result shift pipe, LATENCY deep, cleared at each launch.
    // NOTE: the pipe is small and its valid bits must be known after reset,
    // so every entry is reset rather than left as an unreset memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else if (launch) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= push;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Vector counter, drain counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
            first_err_a <= '0;
            first_err_b <= '0;
`endif
        end else begin
            busy      <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done      <= (state_nxt == DONE);
            err_count <= err_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            if (launch) begin
                vec  <= '0;
                pass <= 1'b0;
            end else if (state == RUN && vec != '1) begin
                // The last vector is held on the outputs instead of wrapping.
                vec <= vec + 1'b1;
            end
            // pass reflects the final compare, which lands on the same edge.
            if (state == DRAIN && state_nxt == DONE) pass <= (err_nxt == '0);
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
            if (launch) begin
                first_err_a <= '0;
                first_err_b <= '0;
            end else if (mismatch && err_count == '0) begin
                first_err_a <= head.ops[VW-1:WIDTH];
                first_err_b <= head.ops[WIDTH-1:0];
            end
`endif
        end
    end

    assign bus.a_out     = vec[VW-1:WIDTH];
    assign bus.b_out     = vec[WIDTH-1:0];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
    assign bus.first_err_a = first_err_a;
    assign bus.first_err_b = first_err_b;
`endif

endmodule

// File: tb/tb_adder_selfcheck_seq.sv
// tb_adder_selfcheck_seq: directed bench for adder_selfcheck_seq. Two DUTs
// (ERR_W=16 and ERR_W=4) share clock, reset and start; each drives its own
// behavioural two-register adder wrapper with optional stuck-at faults.
module tb_adder_selfcheck_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   fault = 0;   // 0 none, 1 sum[0] stuck 0, 2 cout stuck 0
    int   n_checked = 0;
    int   n_failed = 0;

    always #5 clk = ~clk;

    adder_selfcheck_seq_if #(.WIDTH(4), .ERR_W(16)) bus ();
    adder_selfcheck_seq_if #(.WIDTH(4), .ERR_W(4))  sat_bus ();

    adder_selfcheck_seq #(.WIDTH(4), .LATENCY(2), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    adder_selfcheck_seq #(.WIDTH(4), .LATENCY(2), .ERR_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sat_bus)
    );

    // Wrapper models: input register then output register (latency 2).
    logic [3:0] a_q, b_q, sa_q, sb_q;
    logic [4:0] res, sres;
    always @(posedge clk) begin
        a_q  <= bus.a_out;
        b_q  <= bus.b_out;
        res  <= {1'b0, a_q} + {1'b0, b_q};
        sa_q <= sat_bus.a_out;
        sb_q <= sat_bus.b_out;
        sres <= {1'b0, sa_q} + {1'b0, sb_q};
    end

    assign bus.start       = start;
    assign sat_bus.start   = start;
    assign bus.sum_in      = (fault == 1) ? {res[3:1], 1'b0}  : res[3:0];
    assign bus.cout_in     = (fault == 2) ? 1'b0 : res[4];
    assign sat_bus.sum_in  = (fault == 1) ? {sres[3:1], 1'b0} : sres[3:0];
    assign sat_bus.cout_in = (fault == 2) ? 1'b0 : sres[4];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checked++;
        if (observed !== expected) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Launch a sweep at edge 0 and observe 300 cycles at the falling edge.
    // poke_cyc re-asserts start during the sweep; abort_cyc drops rst_n.
    task automatic run_sweep(input int poke_cyc, input int abort_cyc,
                             output int done_cyc, output int busy_cnt, output int done_cnt,
                             output logic busy1, output logic busy_last);
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; busy1 = 1'b0; busy_last = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy",  bus.busy, 0);
                check("abort_a_out", bus.a_out, 0);
                check("abort_b_out", bus.b_out, 0);
                check("abort_err",   bus.err_count, 0);
                check("abort_sat_err", sat_bus.err_count, 0);
                return;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 1)   busy1 = bus.busy;
            if (cyc == 258) busy_last = bus.busy;
        end
    endtask

    int   done_cyc, busy_cnt, done_cnt;
    logic busy1, busy_last;
    int   idle_busy;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_out", bus.a_out, 0);
        check("rst_b_out", bus.b_out, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_pass",  bus.pass, 0);
        check("rst_err",   bus.err_count, 0);
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
        check("rst_first_a", bus.first_err_a, 0);
        check("rst_first_b", bus.first_err_b, 0);
`endif
        @(negedge clk) rst_n = 1'b1;

        // Idle with start low: nothing happens
        idle_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) idle_busy++;
        end
        check("idle_busy", idle_busy, 0);

        // Clean sweep, with an ignored start pulse at cycle 50
        fault = 0;
        run_sweep(50, 0, done_cyc, busy_cnt, done_cnt, busy1, busy_last);
        check("clean_done_cyc", done_cyc, 259);
        check("clean_done_cnt", done_cnt, 1);
        check("clean_busy_cnt", busy_cnt, 258);
        check("clean_busy_c1",  busy1, 1);
        check("clean_busy_c258", busy_last, 1);
        check("clean_err",  bus.err_count, 0);
        check("clean_pass", bus.pass, 1);
        check("clean_sat_err", sat_bus.err_count, 0);
        check("clean_a_hold", bus.a_out, 15);
        check("clean_b_hold", bus.b_out, 15);

        // Stuck sum bit 0: every odd sum mismatches
        fault = 1;
        run_sweep(0, 0, done_cyc, busy_cnt, done_cnt, busy1, busy_last);
        check("sum0_done_cyc", done_cyc, 259);
        check("sum0_err",  bus.err_count, 128);
        check("sum0_pass", bus.pass, 0);
        check("sum0_sat_err",  sat_bus.err_count, 15);
        check("sum0_sat_pass", sat_bus.pass, 0);
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
        check("sum0_first_a", bus.first_err_a, 0);
        check("sum0_first_b", bus.first_err_b, 1);
`endif

        // Stuck carry: every sum >= 16 mismatches
        fault = 2;
        run_sweep(0, 0, done_cyc, busy_cnt, done_cnt, busy1, busy_last);
        check("cout_done_cyc", done_cyc, 259);
        check("cout_err",  bus.err_count, 120);
        check("cout_pass", bus.pass, 0);
`ifdef ADDER_SELFCHECK_FIRSTERR_EN
        check("cout_first_a", bus.first_err_a, 1);
        check("cout_first_b", bus.first_err_b, 15);
`endif

        // Abort mid-sweep with errors accumulating, then a clean relaunch
        fault = 1;
        run_sweep(0, 100, done_cyc, busy_cnt, done_cnt, busy1, busy_last);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        @(negedge clk);
        run_sweep(0, 0, done_cyc, busy_cnt, done_cnt, busy1, busy_last);
        check("relaunch_done_cyc", done_cyc, 259);
        check("relaunch_busy_cnt", busy_cnt, 258);
        check("relaunch_err",  bus.err_count, 0);
        check("relaunch_pass", bus.pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
        $finish;
    end
endmodule
